// File: rtl/bk_pkg.sv
// Shared types and constants for the backup-RAM sector mover.
package bk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    XFER,
    NEXT,
    DONE
  } state_t;

  localparam int unsigned SECT_BYTES = 512;
  localparam int unsigned SECT_SHIFT = 9;

endpackage

// File: rtl/bk_dirty_map.sv
// Per-sector dirty bitmap with a find-first-dirty-at-or-above search.
// Used only when the design is built with BK_DIRTY_EN.
module bk_dirty_map
  import bk_pkg::*;
#(
  parameter int unsigned SECT_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [SECT_LOG2-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [SECT_LOG2-1:0] clr_idx,
  input  logic                 clr_all,
  input  logic [SECT_LOG2-1:0] from_idx,
  output logic                 hit_c,
  output logic [SECT_LOG2-1:0] hit_idx_c
);

  localparam int unsigned NSECT = 1 << SECT_LOG2;

  logic [NSECT-1:0] dirty;

  // Bitmap update; a core write in the same cycle as a clear keeps the sector dirty.
  always_ff @(posedge clk) begin
    if (reset) begin
      dirty <= '0;
    end else begin
      if (clr_all) begin
        dirty <= '0;
      end else if (clr_en) begin
        dirty[clr_idx] <= 1'b0;
      end
      if (set_en) begin
        dirty[set_idx] <= 1'b1;
      end
    end
  end

  // Lowest dirty sector index that is >= from_idx.
  always_comb begin
    hit_c     = 1'b0;
    hit_idx_c = '0;
    for (int i = int'(NSECT) - 1; i >= 0; i--) begin
      if (dirty[i] && (i >= int'(from_idx))) begin
        hit_c     = 1'b1;
        hit_idx_c = SECT_LOG2'(i);
      end
    end
  end

endmodule

// File: rtl/bk_sector_xfer.sv
// Backup-RAM <-> SD-image sector mover: loads the save area after mount,
// writes it back on OSD save requests, pulses a core reset after a load.
// Optional feature macro: BK_DIRTY_EN (save only sectors the core wrote).
module bk_sector_xfer
  import bk_pkg::*;
#(
  parameter int unsigned SECT_LOG2 = 4,
  parameter logic [31:0] LBA_BASE  = 32'd0
) (
  input  logic                            clk_sys,
  input  logic                            reset,
  input  logic                            img_mounted,
  input  logic [31:0]                     img_size,
  input  logic                            ioctl_download,
  input  logic                            bk_save,
  output logic [31:0]                     sd_lba,
  output logic                            sd_rd,
  output logic                            sd_wr,
  input  logic                            sd_ack,
  output logic [SECT_LOG2-1:0]            buf_sector,
  input  logic                            core_we,
  input  logic [SECT_LOG2+SECT_SHIFT-1:0] core_a,
  output logic                            bk_ena,
  output logic                            bk_busy,
  output logic                            bk_reset
);

  localparam int unsigned ADDR_W   = SECT_LOG2 + SECT_SHIFT;
  localparam int unsigned MAX_SECT = 1 << SECT_LOG2;

  state_t                state, state_nxt;
  logic                  mount_q, dl_q, save_q;
  logic                  mount_rise, dl_rise, save_rise, size_ok;
  logic                  load_pend, save_pend, op_load, op_load_nxt;
  logic                  save_take, load_done, reset_nxt, clr_en, clr_all;
  logic                  dirty_hit, save_ok;
  logic [SECT_LOG2-1:0]  dirty_idx, from_idx, buf_nxt, last_sect, last_sect_c;
  logic [31:0]           img_sects;
  logic                  unused_cfg;

  assign mount_rise = img_mounted & ~mount_q;
  assign dl_rise    = ioctl_download & ~dl_q;
  assign save_rise  = bk_save & ~save_q;
  assign size_ok    = (img_size != 32'd0);
  assign img_sects  = img_size >> SECT_SHIFT;

  // Index of the last sector to move: clamp(size/512, 1, 2^SECT_LOG2) - 1.
  always_comb begin
    if (img_sects == 32'd0) begin
      last_sect_c = '0;
    end else if (img_sects >= 32'(MAX_SECT)) begin
      last_sect_c = '1;
    end else begin
      last_sect_c = SECT_LOG2'(img_sects - 32'd1);
    end
  end

  // Search start for the next sector to save.
  assign from_idx = (state == NEXT) ? buf_sector + SECT_LOG2'(1) : '0;
  assign save_ok  = dirty_hit && (dirty_idx <= last_sect);

`ifdef BK_DIRTY_EN
  bk_dirty_map #(
    .SECT_LOG2(SECT_LOG2)
  ) u_dirty (
    .clk      (clk_sys),
    .reset    (reset),
    .set_en   (core_we),
    .set_idx  (core_a[ADDR_W-1 -: SECT_LOG2]),
    .clr_en   (clr_en),
    .clr_idx  (buf_sector),
    .clr_all  (clr_all),
    .from_idx (from_idx),
    .hit_c    (dirty_hit),
    .hit_idx_c(dirty_idx)
  );
  assign unused_cfg = ^core_a[SECT_SHIFT-1:0];
`else
  assign dirty_hit  = 1'b1;
  assign dirty_idx  = from_idx;
  assign unused_cfg = ^{core_we, core_a, clr_en, clr_all};
`endif

  // Edge detectors, enable flag, request queue and latched sector count.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mount_q   <= 1'b0;
      dl_q      <= 1'b0;
      save_q    <= 1'b0;
      bk_ena    <= 1'b0;
      load_pend <= 1'b0;
      save_pend <= 1'b0;
      last_sect <= '0;
    end else begin
      mount_q <= img_mounted;
      dl_q    <= ioctl_download;
      save_q  <= bk_save;
      if (mount_rise) begin
        last_sect <= last_sect_c;
      end
      if (dl_rise || (mount_rise && !size_ok)) begin
        bk_ena    <= 1'b0;
        load_pend <= 1'b0;
        save_pend <= 1'b0;
      end else begin
        if (mount_rise) begin
          bk_ena    <= 1'b1;
          load_pend <= 1'b1;
        end else if (load_done) begin
          load_pend <= 1'b0;
        end
        if (save_rise && (bk_ena || mount_rise)) begin
          save_pend <= 1'b1;
        end else if (save_take) begin
          save_pend <= 1'b0;
        end
      end
    end
  end

  // State register and registered SD/status outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      op_load    <= 1'b0;
      buf_sector <= '0;
      sd_lba     <= '0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      bk_busy    <= 1'b0;
      bk_reset   <= 1'b0;
    end else begin
      state      <= state_nxt;
      op_load    <= op_load_nxt;
      buf_sector <= buf_nxt;
      if (state_nxt == REQ) begin
        sd_lba <= LBA_BASE + 32'(buf_nxt);
      end
      sd_rd    <= (state_nxt == REQ) && op_load_nxt;
      sd_wr    <= (state_nxt == REQ) && !op_load_nxt;
      bk_busy  <= (state_nxt != IDLE);
      bk_reset <= reset_nxt;
    end
  end

  // Next-state logic; a pending load always goes before a pending save.
  always_comb begin
    state_nxt   = state;
    op_load_nxt = op_load;
    buf_nxt     = buf_sector;
    reset_nxt   = 1'b0;
    save_take   = 1'b0;
    load_done   = 1'b0;
    clr_en      = 1'b0;
    clr_all     = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_pend) begin
          op_load_nxt = 1'b1;
          buf_nxt     = '0;
          state_nxt   = REQ;
        end else if (save_pend) begin
          op_load_nxt = 1'b0;
          save_take   = 1'b1;
          if (save_ok) begin
            buf_nxt   = dirty_idx;
            state_nxt = REQ;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      REQ: begin
        if (sd_ack) begin
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (!sd_ack) begin
          clr_en    = !op_load;
          state_nxt = NEXT;
        end
      end
      NEXT: begin
        if ((buf_sector == last_sect) || !bk_ena) begin
          state_nxt = DONE;
        end else if (op_load) begin
          buf_nxt   = from_idx;
          state_nxt = REQ;
        end else if (save_ok) begin
          buf_nxt   = dirty_idx;
          state_nxt = REQ;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        reset_nxt = op_load && bk_ena;
        load_done = op_load;
        clr_all   = op_load;
        buf_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bk_sector_xfer.sv
// Bench for bk_sector_xfer: table of mount sizes, hand-written corner sequences,
// randomized mount/write/save rounds against a sector-list reference model.
module tb_bk_sector_xfer;

  localparam int unsigned SECT_LOG2 = 4;
  localparam logic [31:0] LBA_BASE  = 32'd0;
`ifdef BK_DIRTY_EN
  localparam bit DIRTY = 1'b1;
`else
  localparam bit DIRTY = 1'b0;
`endif

  logic        clk, reset, img_mounted, ioctl_download, bk_save, core_we;
  logic [31:0] img_size, sd_lba;
  logic        sd_rd, sd_wr, sd_ack, ack_auto, ack_man, rsp_off;
  logic [3:0]  buf_sector;
  logic [12:0] core_a;
  logic        bk_ena, bk_busy, bk_reset;

  int total = 0;
  int bad   = 0;
  int rst_pulses = 0, rst_at = 0;
  int proto_err = 0, sect_err = 0, hang_err = 0, gap_err = 0;

  logic [31:0] log_lba[$];
  bit          log_rd[$];
  logic [31:0] exp_lba[$];
  bit          exp_rd[$];

  bit [15:0] mdirty;
  bit        m_ena;
  int        m_n;

  typedef struct {
    logic [31:0] size;
    int          exp_n;
    bit          exp_ena;
    bit          save;
  } vec_t;
  vec_t vecs[8];

  assign sd_ack = ack_auto | ack_man;

  bk_sector_xfer #(.SECT_LOG2(SECT_LOG2), .LBA_BASE(LBA_BASE)) dut (
    .clk_sys(clk), .reset(reset), .img_mounted(img_mounted), .img_size(img_size),
    .ioctl_download(ioctl_download), .bk_save(bk_save), .sd_lba(sd_lba),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .buf_sector(buf_sector),
    .core_we(core_we), .core_a(core_a), .bk_ena(bk_ena), .bk_busy(bk_busy),
    .bk_reset(bk_reset)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // SD responder: random ack latency and hold, logs each acknowledged request.
  initial begin
    ack_auto = 1'b0;
    forever begin
      @(negedge clk);
      if ((sd_rd || sd_wr) && !rsp_off) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        log_rd.push_back(sd_rd);
        log_lba.push_back(sd_lba);
        if (sd_lba != LBA_BASE + 32'(buf_sector)) sect_err++;
        ack_auto = 1'b1;
        for (int k = 0; k < 50 && (sd_rd || sd_wr); k++) @(negedge clk);
        if (sd_rd || sd_wr) hang_err++;
        repeat ($urandom_range(2, 4)) @(negedge clk);
        ack_auto = 1'b0;
        @(negedge clk);
        if (sd_rd || sd_wr) gap_err++;
      end
    end
  end

  // Reset-pulse counter and read/write exclusivity monitor.
  always @(negedge clk) begin
    if (bk_reset) begin
      rst_pulses = rst_pulses + 1;
      rst_at     = log_lba.size();
    end
    if (sd_rd && sd_wr) proto_err++;
  end

  function automatic int nsect_model(input logic [31:0] size);
    int n;
    if (size == 32'd0) return 0;
    n = int'(size / 32'd512);
    if (n < 1) n = 1;
    if (n > 16) n = 16;
    return n;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic check_log(input string name, input int base);
    int n = log_lba.size() - base;
    int errs = 0;
    check({name, "_cnt"}, 64'(n), 64'(exp_lba.size()));
    for (int i = 0; i < n && i < exp_lba.size(); i++)
      if (log_lba[base+i] != exp_lba[i] || log_rd[base+i] != exp_rd[i]) errs++;
    check({name, "_seq"}, 64'(errs), 64'd0);
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0;
    bit ok = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (!bk_busy) quiet++; else quiet = 0;
      if (quiet >= 4) begin ok = 1'b1; break; end
    end
    check({name, "_idle"}, 64'(ok), 64'd1);
  endtask

  task automatic mount(input logic [31:0] size);
    img_size = size;
    img_mounted = 1'b1;
    repeat (2) @(negedge clk);
    img_mounted = 1'b0;
  endtask

  task automatic pulse_save();
    bk_save = 1'b1;
    repeat (2) @(negedge clk);
    bk_save = 1'b0;
  endtask

  task automatic core_write(input logic [12:0] a);
    core_a = a;
    core_we = 1'b1;
    @(negedge clk);
    core_we = 1'b0;
    mdirty[a[12:9]] = 1'b1;
  endtask

  task automatic model_load(input int n);
    exp_lba.delete();
    exp_rd.delete();
    for (int i = 0; i < n; i++) begin
      exp_lba.push_back(LBA_BASE + 32'(i));
      exp_rd.push_back(1'b1);
    end
  endtask

  task automatic model_save();
    exp_lba.delete();
    exp_rd.delete();
    if (m_ena) begin
      for (int i = 0; i < m_n; i++) begin
        if (!DIRTY || mdirty[i]) begin
          exp_lba.push_back(LBA_BASE + 32'(i));
          exp_rd.push_back(1'b0);
        end
        mdirty[i] = 1'b0;
      end
    end
  endtask

  task automatic do_mount(input string name, input logic [31:0] size, input int exp_n, input bit exp_ena);
    int base = log_lba.size();
    int rbase = rst_pulses;
    mount(size);
    wait_idle(name);
    check({name, "_ena"}, 64'(bk_ena), 64'(exp_ena));
    model_load(exp_n);
    check_log({name, "_load"}, base);
    check({name, "_rstpulse"}, 64'(rst_pulses - rbase), 64'((exp_n > 0) ? 1 : 0));
    m_ena = exp_ena;
    m_n = exp_n;
    if (exp_n > 0) mdirty = '0;
  endtask

  task automatic do_save(input string name);
    int base = log_lba.size();
    int rbase = rst_pulses;
    pulse_save();
    wait_idle(name);
    model_save();
    check_log({name, "_save"}, base);
    check({name, "_norst"}, 64'(rst_pulses - rbase), 64'd0);
  endtask

  initial begin
    int base, rbase;
    bit found;
    logic [31:0] rsize;

    vecs[0] = '{32'd8192,    16, 1'b1, 1'b0};
    vecs[1] = '{32'd1024,     2, 1'b1, 1'b1};
    vecs[2] = '{32'd100,      1, 1'b1, 1'b1};
    vecs[3] = '{32'd1048576, 16, 1'b1, 1'b0};
    vecs[4] = '{32'd0,        0, 1'b0, 1'b1};
    vecs[5] = '{32'd3000,     5, 1'b1, 1'b1};
    vecs[6] = '{32'd8704,    16, 1'b1, 1'b0};
    vecs[7] = '{32'd7680,    15, 1'b1, 1'b1};

    reset = 1'b1; img_mounted = 1'b0; img_size = '0; ioctl_download = 1'b0;
    bk_save = 1'b0; core_we = 1'b0; core_a = '0; ack_man = 1'b0; rsp_off = 1'b0;
    mdirty = '0; m_ena = 1'b0; m_n = 0;
    repeat (3) @(negedge clk);
    check("rst_lba", 64'(sd_lba), 64'd0);
    check("rst_rd", 64'(sd_rd), 64'd0);
    check("rst_wr", 64'(sd_wr), 64'd0);
    check("rst_sector", 64'(buf_sector), 64'd0);
    check("rst_ena", 64'(bk_ena), 64'd0);
    check("rst_busy", 64'(bk_busy), 64'd0);
    check("rst_pulse", 64'(bk_reset), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Table: mount sizes covering clamp limits, optional save afterwards.
    for (int v = 0; v < 8; v++) begin
      do_mount($sformatf("vec%0d", v), vecs[v].size, vecs[v].exp_n, vecs[v].exp_ena);
      if (vecs[v].save) do_save($sformatf("vec%0d", v));
    end

    // Save edge during load of sector 5: load completes, reset pulse, then full save.
    base = log_lba.size();
    rbase = rst_pulses;
    mount(32'd8192);
    found = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (buf_sector == 4'd5 && sd_rd) begin found = 1'b1; break; end
    end
    check("q_reach5", 64'(found), 64'd1);
    pulse_save();
    wait_idle("q");
    mdirty = '0;
    m_ena = 1'b1;
    m_n = 16;
    model_load(16);
    model_save();
    for (int i = 0; i < 16; i++) begin
      exp_lba.push_front(LBA_BASE + 32'(15 - i));
      exp_rd.push_front(1'b1);
    end
    check_log("q", base);
    check("q_rstpulse", 64'(rst_pulses - rbase), 64'd1);
    check("q_rst_order", 64'(rst_at - base), 64'd16);

    // Download rises in XFER of sector 3: sector 3 finishes, nothing more, no reset.
    base = log_lba.size();
    rbase = rst_pulses;
    mount(32'd8192);
    found = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (buf_sector == 4'd3 && sd_ack && !sd_rd && bk_busy) begin found = 1'b1; break; end
    end
    check("dl_reach3", 64'(found), 64'd1);
    ioctl_download = 1'b1;
    wait_idle("dl");
    model_load(4);
    check_log("dl", base);
    check("dl_ena", 64'(bk_ena), 64'd0);
    check("dl_norst", 64'(rst_pulses - rbase), 64'd0);
    m_ena = 1'b0;
    mdirty = '0;
    do_save("dl");
    ioctl_download = 1'b0;
    @(negedge clk);

    // Reset while a read request is outstanding; acks afterwards are ignored.
    rsp_off = 1'b1;
    mount(32'd8192);
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (sd_rd) begin found = 1'b1; break; end
    end
    check("rr_req", 64'(found), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rr_rd", 64'(sd_rd), 64'd0);
    check("rr_busy", 64'(bk_busy), 64'd0);
    check("rr_ena", 64'(bk_ena), 64'd0);
    ack_man = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rr_rd_after", 64'(sd_rd | sd_wr), 64'd0);
    check("rr_busy_after", 64'(bk_busy), 64'd0);
    ack_man = 1'b0;
    rsp_off = 1'b0;
    m_ena = 1'b0;
    mdirty = '0;
    @(negedge clk);

`ifdef BK_DIRTY_EN
    // Dirty tracking: writes to sectors 1 and 15 save only those; a second save is silent.
    do_mount("dm", 32'd8192, 16, 1'b1);
    core_write(13'h0200);
    core_write(13'h1E00);
    base = log_lba.size();
    pulse_save();
    wait_idle("dm");
    exp_lba.delete();
    exp_rd.delete();
    exp_lba.push_back(32'd1);  exp_rd.push_back(1'b0);
    exp_lba.push_back(32'd15); exp_rd.push_back(1'b0);
    check_log("dm_save", base);
    mdirty = '0;
    do_save("dm_clean");
`endif

    // Randomized rounds: random image size, random core writes, then save.
    for (int r = 0; r < 6; r++) begin
      rsize = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 12000));
      do_mount($sformatf("rnd%0d", r), rsize, nsect_model(rsize), rsize != 32'd0);
      for (int w = 0; w < int'($urandom_range(0, 3)); w++)
        core_write(13'($urandom_range(0, 8191)));
      do_save($sformatf("rnd%0d", r));
    end

    check("proto_rd_wr", 64'(proto_err), 64'd0);
    check("lba_vs_sector", 64'(sect_err), 64'd0);
    check("req_drop", 64'(hang_err), 64'd0);
    check("req_gap", 64'(gap_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
